// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight destinations and stalls issue on unforwardable RAW operands.
// Optional WAW stall enabled by defining HAZARD_SCOREBOARD_WAW_CHECK_EN.
module hazard_scoreboard #(
  parameter int REG_COUNT     = 32,
  parameter int INDEX_WIDTH   = 5,
  parameter int LATENCY_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [INDEX_WIDTH-1:0]   issue_rd,
  input  logic [LATENCY_WIDTH-1:0] issue_latency,
  input  logic [INDEX_WIDTH-1:0]   issue_rs1,
  input  logic [INDEX_WIDTH-1:0]   issue_rs2,
  input  logic                     issue_rs1_used,
  input  logic                     issue_rs2_used,
  input  logic                     complete_valid,
  input  logic [INDEX_WIDTH-1:0]   complete_rd,
  input  logic                     writeback_valid,
  input  logic [INDEX_WIDTH-1:0]   writeback_rd,
  output logic                     stall,
  output logic                     issue_fire,
  output logic [5:0]               pending_count,
  output logic                     idle
);

  localparam logic [LATENCY_WIDTH-1:0] CNT_ZERO = {LATENCY_WIDTH{1'b0}};
  localparam logic [LATENCY_WIDTH-1:0] CNT_ONE  = {{(LATENCY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH-1:0]   IDX_ZERO = {INDEX_WIDTH{1'b0}};

  logic [REG_COUNT-1:0]     pending_r;
  logic [REG_COUNT-1:0]     var_lat_r;
  logic [LATENCY_WIDTH-1:0] count_r [REG_COUNT];

  logic [REG_COUNT-1:0]     pending_n_s;
  logic [REG_COUNT-1:0]     var_lat_n_s;
  logic [LATENCY_WIDTH-1:0] count_n_s [REG_COUNT];
  logic [5:0]               count_sum_s;

  logic rs1_hit_s;
  logic rs2_hit_s;
  logic waw_hit_s;

  // Hazard detection looks only at current state, never at this cycle's strobes.
  always_comb begin
    rs1_hit_s = issue_rs1_used && (issue_rs1 != IDX_ZERO) && pending_r[issue_rs1] &&
                (var_lat_r[issue_rs1] || (count_r[issue_rs1] != CNT_ZERO));
    rs2_hit_s = issue_rs2_used && (issue_rs2 != IDX_ZERO) && pending_r[issue_rs2] &&
                (var_lat_r[issue_rs2] || (count_r[issue_rs2] != CNT_ZERO));
`ifdef HAZARD_SCOREBOARD_WAW_CHECK_EN
    waw_hit_s = (issue_rd != IDX_ZERO) && pending_r[issue_rd];
`else
    waw_hit_s = 1'b0;
`endif
    stall      = issue_valid && (rs1_hit_s || rs2_hit_s || waw_hit_s);
    issue_fire = issue_valid && !stall;
  end

  // Next-state per entry: countdown first, then strobes with issue > complete > writeback.
  always_comb begin
    pending_n_s = pending_r;
    var_lat_n_s = var_lat_r;
    count_n_s   = count_r;
    count_sum_s = 6'd0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (pending_r[i] && !var_lat_r[i] && (count_r[i] != CNT_ZERO)) begin
        count_n_s[i] = count_r[i] - CNT_ONE;
      end else begin
        count_n_s[i] = count_r[i];
      end
      if (issue_fire && (issue_rd == INDEX_WIDTH'(i))) begin
        pending_n_s[i] = 1'b1;
        if (issue_latency == CNT_ZERO) begin
          var_lat_n_s[i] = 1'b1;
          count_n_s[i]   = CNT_ZERO;
        end else begin
          var_lat_n_s[i] = 1'b0;
          count_n_s[i]   = issue_latency - CNT_ONE;
        end
      end else if (complete_valid && (complete_rd == INDEX_WIDTH'(i)) && pending_r[i] && var_lat_r[i]) begin
        var_lat_n_s[i] = 1'b0;
        count_n_s[i]   = CNT_ZERO;
      end else if (writeback_valid && (writeback_rd == INDEX_WIDTH'(i))) begin
        pending_n_s[i] = 1'b0;
        var_lat_n_s[i] = 1'b0;
        count_n_s[i]   = CNT_ZERO;
      end else begin
        pending_n_s[i] = pending_r[i];
      end
      if (pending_n_s[i]) begin
        count_sum_s = count_sum_s + 6'd1;
      end else begin
        count_sum_s = count_sum_s;
      end
    end
    pending_n_s[0] = 1'b0;
    var_lat_n_s[0] = 1'b0;
    count_n_s[0]   = CNT_ZERO;
  end

  // State and status registers; status mirrors next-state so it is exact one cycle after an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r     <= {REG_COUNT{1'b0}};
      var_lat_r     <= {REG_COUNT{1'b0}};
      for (int i = 0; i < REG_COUNT; i++) begin
        count_r[i] <= CNT_ZERO;
      end
      pending_count <= 6'd0;
      idle          <= 1'b1;
    end else begin
      pending_r     <= pending_n_s;
      var_lat_r     <= var_lat_n_s;
      for (int i = 0; i < REG_COUNT; i++) begin
        count_r[i] <= count_n_s[i];
      end
      pending_count <= count_sum_s;
      idle          <= (count_sum_s == 6'd0);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios then random traffic against a
// model that tracks, per register, whether it is pending and the absolute cycle it becomes forwardable.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [2:0] issue_latency;
  logic [4:0] issue_rs1, issue_rs2;
  logic       issue_rs1_used, issue_rs2_used;
  logic       complete_valid;
  logic [4:0] complete_rd;
  logic       writeback_valid;
  logic [4:0] writeback_rd;
  logic       stall, issue_fire, idle;
  logic [5:0] pending_count;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_latency(issue_latency), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .complete_valid(complete_valid), .complete_rd(complete_rd),
    .writeback_valid(writeback_valid), .writeback_rd(writeback_rd),
    .stall(stall), .issue_fire(issue_fire), .pending_count(pending_count), .idle(idle)
  );

  localparam int NEVER = 32'h7fffffff;
`ifdef HAZARD_SCOREBOARD_WAW_CHECK_EN
  localparam logic WAW = 1'b1;
`else
  localparam logic WAW = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit m_pend [32];
  int m_fwd  [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_blocked(input int r);
    return (r != 0) && m_pend[r] && (cyc < m_fwd[r]);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = (issue_rs1_used && m_blocked(int'(issue_rs1))) || (issue_rs2_used && m_blocked(int'(issue_rs2)));
    if (WAW && (issue_rd != 5'd0) && m_pend[issue_rd]) s = 1'b1;
    return issue_valid && s;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 1; r < 32; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic drive(input logic iv, input logic [4:0] rd, input logic [2:0] lat,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic cv, input logic [4:0] crd, input logic wv, input logic [4:0] wrd);
    issue_valid = iv; issue_rd = rd; issue_latency = lat;
    issue_rs1 = r1; issue_rs1_used = u1; issue_rs2 = r2; issue_rs2_used = u2;
    complete_valid = cv; complete_rd = crd; writeback_valid = wv; writeback_rd = wrd;
    #1;
    check("stall", {31'd0, stall}, {31'd0, m_stall()});
    check("issue_fire", {31'd0, issue_fire}, {31'd0, issue_valid && !m_stall()});
  endtask

  task automatic tick();
    bit fire, do_cmp;
    fire   = issue_valid && !m_stall();
    do_cmp = complete_valid && (complete_rd != 5'd0) && m_pend[complete_rd] && (m_fwd[complete_rd] == NEVER);
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_pend[r] = 1'b0; m_fwd[r] = 0; end
    end else begin
      if (writeback_valid && writeback_rd != 5'd0) m_pend[writeback_rd] = 1'b0;
      if (do_cmp) begin m_pend[complete_rd] = 1'b1; m_fwd[complete_rd] = cyc + 1; end
      if (fire && issue_rd != 5'd0) begin
        m_pend[issue_rd] = 1'b1;
        m_fwd[issue_rd]  = (issue_latency == 3'd0) ? NEVER : cyc + int'(issue_latency);
      end
    end
    cyc++;
    @(negedge clk);
    check("pending_count", {26'd0, pending_count}, m_count());
    check("idle", {31'd0, idle}, {31'd0, m_count() == 0});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_latency = 3'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; complete_valid = 1'b0; complete_rd = 5'd0;
    writeback_valid = 1'b0; writeback_rd = 5'd0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic iv, u1, u2, cv, wv;
    logic [4:0] rd, r1, r2, crd, wrd;
    logic [2:0] lat;
    @(negedge clk);
    do_reset();
    check("reset_count", {26'd0, pending_count}, 32'd0);
    check("reset_idle", {31'd0, idle}, 32'd1);

    // Fixed latency 2 producer: one stall cycle for a dependent
    drive(1, 5'd5, 3'd2, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0); tick();
    drive(1, 5'd0, 3'd1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("lat2_stall", {31'd0, stall}, 32'd1); tick();
    drive(1, 5'd0, 3'd1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("lat2_release", {31'd0, stall}, 32'd0);
    check("lat2_fire", {31'd0, issue_fire}, 32'd1); tick();

    // Variable latency producer released the cycle after complete
    do_reset();
    drive(1, 5'd7, 3'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'd0, 3'd1, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0, 5'd0);
      check("var_wait", {31'd0, stall}, 32'd1); tick();
    end
    drive(1, 5'd0, 3'd1, 5'd0, 0, 5'd7, 1, 1, 5'd7, 0, 5'd0);
    check("var_cmp_cycle", {31'd0, stall}, 32'd1); tick();
    drive(1, 5'd0, 3'd1, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0, 5'd0);
    check("var_released", {31'd0, stall}, 32'd0); tick();
    check("var_count", {26'd0, pending_count}, 32'd1);
    drive(0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7); tick();
    check("var_wb_count", {26'd0, pending_count}, 32'd0);
    check("var_wb_idle", {31'd0, idle}, 32'd1);

    // Issue and writeback on the same rd: new entry survives
    do_reset();
    drive(1, 5'd3, 3'd1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd3); tick();
    check("iss_wb_count", {26'd0, pending_count}, 32'd1);

    // x0 never tracked
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd0, 3'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 1, 5'd0);
      check("x0_stall", {31'd0, stall}, 32'd0); tick();
      check("x0_count", {26'd0, pending_count}, 32'd0);
    end

    // Reissue of a pending destination
    do_reset();
    drive(1, 5'd9, 3'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0); tick();
    drive(1, 5'd9, 3'd1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("waw_stall", {31'd0, stall}, {31'd0, WAW}); tick();
    drive(1, 5'd9, 3'd1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd9);
    check("waw_wb_cycle", {31'd0, stall}, {31'd0, WAW}); tick();
    drive(1, 5'd9, 3'd1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("waw_after", {31'd0, stall}, 32'd0); tick();
    check("waw_count", {26'd0, pending_count}, 32'd1);

    // Reset discards in-flight tracking
    do_reset();
    for (int k = 4; k <= 6; k++) begin
      drive(1, 5'(k), 3'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0); tick();
    end
    check("pre_reset_count", {26'd0, pending_count}, 32'd3);
    do_reset();
    check("post_reset_count", {26'd0, pending_count}, 32'd0);
    check("post_reset_idle", {31'd0, idle}, 32'd1);
    drive(1, 5'd0, 3'd1, 5'd4, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("post_reset_stall", {31'd0, stall}, 32'd0); tick();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      if (n % 200 == 199) do_reset();
      iv  = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 7));
      lat = 3'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      cv  = ($urandom_range(0, 2) == 0);
      crd = 5'($urandom_range(1, 7));
      wv  = ($urandom_range(0, 2) == 0);
      wrd = 5'($urandom_range(0, 7));
      if (cv && wv && crd == wrd) wv = 1'b0;
      drive(iv, rd, lat, r1, u1, r2, u2, cv, crd, wv, wrd);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
